// File: rtl/capi_put_plus.sv
// rtl/capi_put_plus.sv - host-write engine: splits one put command into 512B-aligned write requests
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   put_addr/ctxt/size   client command (ea, context, byte size multiple of 16)
//   put_valid/put_acc    command handshake, only accepted while idle
//   put_data_v/r/d       client 16B data beats, 128 data + 2 odd parity bits
//   o_req_v/r/d          write request {uid,tag,ctxt,ea,tsize}
//   o_wdata_v/r/a/d      write data, addressed {uid,tag,beat}
//   i_rsp_v/d            write response {rc,uid,tag}
//   o_rsp_miss           one-cycle pulse: our uid but tag not outstanding
//   put_done_v/r/rc      single completion carrying the OR of all response rcs
//   o_perror             sticky data parity error
module capi_put_plus #(
  parameter int uid_width    = 5,
  parameter int uid          = 0,
  parameter int tag_width    = 8,
  parameter int ea_width     = 64,
  parameter int ctxtid_width = 9,
  parameter int ssize_width  = 18,
  parameter int tsize_width  = 12,
  parameter int rc_width     = 1
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic [ea_width-1:0]                                     put_addr,
  input  logic [ctxtid_width-1:0]                                 put_ctxt,
  input  logic [ssize_width-1:0]                                  put_size,
  input  logic                                                    put_valid,
  output logic                                                    put_acc,
  input  logic                                                    put_data_v,
  output logic                                                    put_data_r,
  input  logic [129:0]                                            put_data_d,
  output logic                                                    o_req_v,
  input  logic                                                    o_req_r,
  output logic [tag_width+ctxtid_width+ea_width+tsize_width-1:0]  o_req_d,
  output logic                                                    o_wdata_v,
  input  logic                                                    o_wdata_r,
  output logic [tag_width+4:0]                                    o_wdata_a,
  output logic [129:0]                                            o_wdata_d,
  input  logic                                                    i_rsp_v,
  input  logic [rc_width+tag_width-1:0]                           i_rsp_d,
  output logic                                                    o_rsp_miss,
  output logic                                                    put_done_v,
  input  logic                                                    put_done_r,
  output logic [rc_width-1:0]                                     put_done_rc,
  output logic                                                    o_perror
);

  localparam int lcl   = tag_width - uid_width;
  localparam int ntags = 1 << lcl;
  localparam int req_w = tag_width + ctxtid_width + ea_width + tsize_width;
  localparam logic [uid_width-1:0] uid_v = uid_width'(uid);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_REQ,
    S_DATA,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ea_width-1:0]     ea_q;
  logic [ctxtid_width-1:0] ctxt_q;
  logic [ssize_width-1:0]  rem_q;
  logic [tsize_width-1:0]  chunk_q;
  logic [lcl-1:0]          tag_q;
  logic [4:0]              beat_q;
  logic [req_w-1:0]        req_q;
  logic [ntags-1:0]        out_vec;
  logic [lcl:0]            out_cnt;
  logic [rc_width-1:0]     rc_acc;
  logic                    miss_q;
  logic                    perr_q;

  // Lowest-index free tag. Uses the registered pool, so a tag freed this
  // cycle only becomes allocatable next cycle.
  logic           free_found;
  logic [lcl-1:0] free_tag;

  always_comb begin
    free_found = 1'b0;
    free_tag   = '0;
    for (int i = ntags - 1; i >= 0; i--) begin
      if (!out_vec[i]) begin
        free_found = 1'b1;
        free_tag   = i[lcl-1:0];
      end
    end
  end

  // Bytes left before the next 512B boundary (1..512).
  logic [9:0]             room;
  logic [tsize_width-1:0] chunk_calc;

  assign room = 10'd512 - {1'b0, ea_q[8:0]};

  always_comb begin
    chunk_calc = tsize_width'(room);
    if (rem_q < ssize_width'(room)) begin
      chunk_calc = tsize_width'(rem_q);
    end
  end

  // Response decode: {rc, uid, local tag}.
  logic [rc_width-1:0]  rsp_rc;
  logic [uid_width-1:0] rsp_uid;
  logic [lcl-1:0]       rsp_tag;
  logic                 rsp_match;
  logic                 rsp_hit;
  logic                 rsp_miss;

  assign rsp_rc    = i_rsp_d[rc_width+tag_width-1:tag_width];
  assign rsp_uid   = i_rsp_d[tag_width-1:lcl];
  assign rsp_tag   = i_rsp_d[lcl-1:0];
  assign rsp_match = i_rsp_v && (rsp_uid == uid_v);
  assign rsp_hit   = rsp_match && out_vec[rsp_tag];
  assign rsp_miss  = rsp_match && !out_vec[rsp_tag];

  logic alloc;
  logic xfer;
  logic last_beat;
  logic par_bad;

  assign alloc     = (state == S_CALC) && free_found;
  assign xfer      = (state == S_DATA) && put_data_v && o_wdata_r;
  // chunk is at most 512, so chunk/16 fits in 6 bits.
  assign last_beat = ({1'b0, beat_q} == (chunk_q[9:4] - 6'd1));
  // Odd parity per 64b half: bit 128 covers [63:0], bit 129 covers [127:64].
  assign par_bad   = !(^{put_data_d[128], put_data_d[63:0]}) ||
                     !(^{put_data_d[129], put_data_d[127:64]});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    put_acc     = 1'b0;
    o_req_v     = 1'b0;
    o_wdata_v   = 1'b0;
    put_data_r  = 1'b0;
    o_wdata_a   = '0;
    o_wdata_d   = '0;
    put_done_v  = 1'b0;
    put_done_rc = '0;
    case (state)
      S_IDLE: begin
        // Gate with reset so the accept stays low while reset is held.
        put_acc = put_valid && reset;
        if (put_acc) begin
          state_nxt = (put_size == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (free_found) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        o_req_v = 1'b1;
        if (o_req_r) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        o_wdata_v  = put_data_v;
        put_data_r = o_wdata_r;
        o_wdata_a  = {uid_v, tag_q, beat_q};
        o_wdata_d  = put_data_d;
        if (xfer && last_beat) begin
          state_nxt = (rem_q == ssize_width'(chunk_q)) ? S_WAIT : S_CALC;
        end
      end
      S_WAIT: begin
        if (out_cnt == '0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        put_done_v  = 1'b1;
        put_done_rc = rc_acc;
        if (put_done_r) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ea_q    <= '0;
      ctxt_q  <= '0;
      rem_q   <= '0;
      chunk_q <= '0;
      tag_q   <= '0;
      beat_q  <= '0;
      req_q   <= '0;
    end else begin
      if (put_acc) begin
        ea_q   <= put_addr;
        ctxt_q <= put_ctxt;
        rem_q  <= put_size;
      end
      if (alloc) begin
        tag_q   <= free_tag;
        chunk_q <= chunk_calc;
        req_q   <= {uid_v, free_tag, ctxt_q, ea_q, chunk_calc};
      end
      if ((state == S_REQ) && o_req_r) begin
        beat_q <= '0;
      end
      if (xfer) begin
        if (last_beat) begin
          ea_q  <= ea_q + ea_width'(chunk_q);
          rem_q <= rem_q - ssize_width'(chunk_q);
        end else begin
          beat_q <= beat_q + 5'd1;
        end
      end
    end
  end

  // Tag pool and accounting. An allocated tag is never outstanding, so a
  // same-cycle allocate and free always touch different bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vec <= '0;
      out_cnt <= '0;
      rc_acc  <= '0;
      miss_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      if (rsp_hit) begin
        out_vec[rsp_tag] <= 1'b0;
      end
      if (alloc) begin
        out_vec[free_tag] <= 1'b1;
      end
      out_cnt <= out_cnt + {{lcl{1'b0}}, alloc} - {{lcl{1'b0}}, rsp_hit};
      if ((state == S_DONE) && put_done_r) begin
        rc_acc <= '0;
      end else if (rsp_hit) begin
        rc_acc <= rc_acc | rsp_rc;
      end
      miss_q <= rsp_miss;
      if (xfer && par_bad) begin
        perr_q <= 1'b1;
      end
    end
  end

  assign o_req_d    = req_q;
  assign o_rsp_miss = miss_q;
  assign o_perror   = perr_q;

endmodule

// File: tb/tb_capi_put_plus.sv
// tb/tb_capi_put_plus.sv - directed self-checking bench for capi_put_plus (6-bit uid, 4 local tags)
module tb_capi_put_plus;

  localparam int UIDW = 6;
  localparam int TAGW = 8;
  localparam int EAW  = 64;
  localparam int CTXW = 9;
  localparam int SSW  = 18;
  localparam int TSW  = 12;
  localparam int RCW  = 1;
  localparam logic [5:0] UIDV = 6'd5;
  localparam logic [5:0] UIDX = 6'd9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          reset;
  logic [EAW-1:0]                put_addr;
  logic [CTXW-1:0]               put_ctxt;
  logic [SSW-1:0]                put_size;
  logic                          put_valid;
  logic                          put_acc;
  logic                          put_data_v;
  logic                          put_data_r;
  logic [129:0]                  put_data_d;
  logic                          o_req_v;
  logic                          o_req_r;
  logic [TAGW+CTXW+EAW+TSW-1:0]  o_req_d;
  logic                          o_wdata_v;
  logic                          o_wdata_r;
  logic [TAGW+4:0]               o_wdata_a;
  logic [129:0]                  o_wdata_d;
  logic                          i_rsp_v;
  logic [RCW+TAGW-1:0]           i_rsp_d;
  logic                          o_rsp_miss;
  logic                          put_done_v;
  logic                          put_done_r;
  logic [RCW-1:0]                put_done_rc;
  logic                          o_perror;

  int checks = 0;
  int errors = 0;
  logic [CTXW-1:0] cur_ctxt;
  logic            perr_exp;

  capi_put_plus #(
    .uid_width(UIDW), .uid(5), .tag_width(TAGW), .ea_width(EAW),
    .ctxtid_width(CTXW), .ssize_width(SSW), .tsize_width(TSW), .rc_width(RCW)
  ) dut (
    .clk(clk), .reset(reset),
    .put_addr(put_addr), .put_ctxt(put_ctxt), .put_size(put_size),
    .put_valid(put_valid), .put_acc(put_acc),
    .put_data_v(put_data_v), .put_data_r(put_data_r), .put_data_d(put_data_d),
    .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_d(o_req_d),
    .o_wdata_v(o_wdata_v), .o_wdata_r(o_wdata_r), .o_wdata_a(o_wdata_a), .o_wdata_d(o_wdata_d),
    .i_rsp_v(i_rsp_v), .i_rsp_d(i_rsp_d), .o_rsp_miss(o_rsp_miss),
    .put_done_v(put_done_v), .put_done_r(put_done_r), .put_done_rc(put_done_rc),
    .o_perror(o_perror)
  );

  task automatic chk(input string name, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [129:0] mk_beat(input int i);
    logic [127:0] d;
    d = {32'hA5C3_0000 + 32'(i * 7), 32'(i) ^ 32'h1234_5678,
         64'h0101_0101_0101_0101 * 64'(i + 1)};
    return {~^d[127:64], ~^d[63:0], d};
  endfunction

  task automatic clear_inputs();
    put_addr = '0; put_ctxt = '0; put_size = '0; put_valid = 1'b0;
    put_data_v = 1'b0; put_data_d = '0; o_req_r = 1'b0; o_wdata_r = 1'b0;
    i_rsp_v = 1'b0; i_rsp_d = '0; put_done_r = 1'b0;
  endtask

  // Drive every input active while reset is low and require all outputs quiet.
  task automatic check_all_zero(input string name);
    put_valid = 1'b1; put_size = 18'h40; put_data_v = 1'b1; put_data_d = mk_beat(3);
    o_wdata_r = 1'b1; o_req_r = 1'b1; put_done_r = 1'b1;
    i_rsp_v = 1'b1; i_rsp_d = {1'b1, UIDV, 2'd0};
    #1;
    chk({name, "_put_acc"}, put_acc, 0);
    chk({name, "_req_v"}, o_req_v, 0);
    chk({name, "_req_d"}, o_req_d, 0);
    chk({name, "_wdata_v"}, o_wdata_v, 0);
    chk({name, "_data_r"}, put_data_r, 0);
    chk({name, "_wdata_a"}, o_wdata_a, 0);
    chk({name, "_wdata_d"}, o_wdata_d, 0);
    chk({name, "_done_v"}, put_done_v, 0);
    chk({name, "_done_rc"}, put_done_rc, 0);
    chk({name, "_perror"}, o_perror, 0);
    tick();
    chk({name, "_miss"}, o_rsp_miss, 0);
    chk({name, "_req_v2"}, o_req_v, 0);
    clear_inputs();
  endtask

  task automatic issue_cmd(input logic [EAW-1:0] ea, input logic [SSW-1:0] size,
                           input logic [CTXW-1:0] ctxt);
    put_addr = ea; put_size = size; put_ctxt = ctxt; put_valid = 1'b1;
    cur_ctxt = ctxt;
    #1;
    chk("put_acc", put_acc, 1);
    tick();
    put_valid = 1'b0;
  endtask

  task automatic expect_req(input string name, input logic [1:0] tag,
                            input logic [EAW-1:0] ea, input logic [TSW-1:0] ts);
    int n;
    n = 0;
    while (!o_req_v && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_req_v"}, o_req_v, 1);
    chk({name, "_req_d"}, o_req_d, {UIDV, tag, cur_ctxt, ea, ts});
  endtask

  task automatic take_req();
    o_req_r = 1'b1;
    tick();
    o_req_r = 1'b0;
  endtask

  task automatic send_beats(input string name, input int n, input logic [1:0] tag, input int bad);
    logic [129:0] d;
    for (int i = 0; i < n; i++) begin
      d = mk_beat(i);
      if (i == bad) d[128] = ~d[128];
      put_data_d = d; put_data_v = 1'b1; o_wdata_r = 1'b1;
      #1;
      chk({name, "_wdata_v"}, o_wdata_v, 1);
      chk({name, "_data_r"}, put_data_r, 1);
      chk({name, "_wdata_a"}, o_wdata_a, {UIDV, tag, 5'(i)});
      chk({name, "_wdata_d"}, o_wdata_d, d);
      tick();
      if (i == bad) perr_exp = 1'b1;
      chk({name, "_perror"}, o_perror, perr_exp);
    end
    put_data_v = 1'b0; o_wdata_r = 1'b0;
  endtask

  task automatic send_rsp(input string name, input logic rc, input logic [5:0] u,
                          input logic [1:0] tag, input logic exp_miss);
    i_rsp_v = 1'b1; i_rsp_d = {rc, u, tag};
    tick();
    i_rsp_v = 1'b0; i_rsp_d = '0;
    chk({name, "_miss"}, o_rsp_miss, exp_miss);
  endtask

  task automatic wait_done(input string name, input logic exp_rc);
    int n;
    n = 0;
    while (!put_done_v && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_done_v"}, put_done_v, 1);
    chk({name, "_done_rc"}, put_done_rc, exp_rc);
    put_done_r = 1'b1;
    tick();
    put_done_r = 1'b0;
    chk({name, "_done_clr"}, put_done_v, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    perr_exp = 1'b0;
    cur_ctxt = '0;
    reset = 1'b0;
    tick();
    check_all_zero("rst");
    reset = 1'b1;
    tick();

    // Two full 512B requests from an aligned ea.
    issue_cmd(64'h1000, 18'h400, 9'h1A5);
    expect_req("a0", 2'd0, 64'h1000, 12'h200);
    take_req();
    send_beats("a0", 32, 2'd0, -1);
    expect_req("a1", 2'd1, 64'h1200, 12'h200);
    take_req();
    send_beats("a1", 32, 2'd1, -1);
    chk("a_wait_nodone", put_done_v, 0);
    send_rsp("a_r0", 1'b0, UIDV, 2'd0, 1'b0);
    chk("a_one_left", put_done_v, 0);
    send_rsp("a_r1", 1'b0, UIDV, 2'd1, 1'b0);
    wait_done("a", 1'b0);

    // Unaligned start: 16B up to the boundary, then 48B.
    issue_cmd(64'h1F0, 18'h40, 9'h033);
    expect_req("b0", 2'd0, 64'h1F0, 12'h010);
    take_req();
    send_beats("b0", 1, 2'd0, -1);
    expect_req("b1", 2'd1, 64'h200, 12'h030);
    take_req();
    send_beats("b1", 3, 2'd1, -1);
    send_rsp("b_foreign", 1'b1, UIDX, 2'd0, 1'b0);
    tick();
    chk("b_foreign_nodone", put_done_v, 0);
    send_rsp("b_r0", 1'b0, UIDV, 2'd0, 1'b0);
    send_rsp("b_r1", 1'b0, UIDV, 2'd1, 1'b0);
    wait_done("b", 1'b0);

    // Zero-size command completes with no traffic.
    issue_cmd(64'h2000, 18'h0, 9'h011);
    put_data_v = 1'b1; o_wdata_r = 1'b1;
    #1;
    chk("z_req_v", o_req_v, 0);
    chk("z_wdata_v", o_wdata_v, 0);
    put_data_v = 1'b0; o_wdata_r = 1'b0;
    wait_done("z", 1'b0);

    // Three requests; one rc=1 response; stray tag raises a miss.
    issue_cmd(64'h1F0, 18'h220, 9'h0F3);
    expect_req("c0", 2'd0, 64'h1F0, 12'h010);
    take_req();
    send_beats("c0", 1, 2'd0, -1);
    expect_req("c1", 2'd1, 64'h200, 12'h200);
    take_req();
    send_beats("c1", 32, 2'd1, -1);
    expect_req("c2", 2'd2, 64'h400, 12'h010);
    take_req();
    send_beats("c2", 1, 2'd2, -1);
    send_rsp("c_r1", 1'b1, UIDV, 2'd1, 1'b0);
    chk("c_nodone1", put_done_v, 0);
    send_rsp("c_stray", 1'b0, UIDV, 2'd3, 1'b1);
    tick();
    chk("c_miss_pulse_end", o_rsp_miss, 0);
    send_rsp("c_foreign", 1'b0, UIDX, 2'd0, 1'b0);
    send_rsp("c_r0", 1'b0, UIDV, 2'd0, 1'b0);
    chk("c_nodone2", put_done_v, 0);
    send_rsp("c_r2", 1'b0, UIDV, 2'd2, 1'b0);
    wait_done("c", 1'b1);

    // 4 KB with only 4 local tags: stall in CALC, reuse lowest freed tag.
    issue_cmd(64'h0, 18'h1000, 9'h100);
    for (int r = 0; r < 4; r++) begin
      expect_req("d_fill", 2'(r), 64'(r * 512), 12'h200);
      take_req();
      send_beats("d_fill", 32, 2'(r), -1);
    end
    for (int k = 0; k < 4; k++) begin
      chk("d_stall", o_req_v, 0);
      tick();
    end
    send_rsp("d_f2", 1'b0, UIDV, 2'd2, 1'b0);
    expect_req("d4", 2'd2, 64'h800, 12'h200);
    take_req();
    send_beats("d4", 32, 2'd2, -1);
    tick();
    chk("d_stall2", o_req_v, 0);
    send_rsp("d_f0", 1'b0, UIDV, 2'd0, 1'b0);
    expect_req("d5", 2'd0, 64'hA00, 12'h200);
    send_rsp("d_f3", 1'b0, UIDV, 2'd3, 1'b0);
    send_rsp("d_f1", 1'b0, UIDV, 2'd1, 1'b0);
    expect_req("d5_hold", 2'd0, 64'hA00, 12'h200);
    take_req();
    send_beats("d5", 32, 2'd0, -1);
    expect_req("d6", 2'd1, 64'hC00, 12'h200);
    take_req();
    send_beats("d6", 32, 2'd1, -1);
    expect_req("d7", 2'd3, 64'hE00, 12'h200);
    take_req();
    send_beats("d7", 32, 2'd3, -1);
    chk("d_wait_nodone", put_done_v, 0);
    send_rsp("d_r2", 1'b0, UIDV, 2'd2, 1'b0);
    send_rsp("d_r0", 1'b0, UIDV, 2'd0, 1'b0);
    send_rsp("d_r1", 1'b0, UIDV, 2'd1, 1'b0);
    send_rsp("d_r3", 1'b0, UIDV, 2'd3, 1'b0);
    wait_done("d", 1'b0);

    // Bad parity on beat 5: flagged, data still forwarded, flag sticky.
    issue_cmd(64'h3000, 18'h80, 9'h055);
    expect_req("e0", 2'd0, 64'h3000, 12'h080);
    take_req();
    send_beats("e0", 8, 2'd0, 5);
    send_rsp("e_r0", 1'b0, UIDV, 2'd0, 1'b0);
    wait_done("e", 1'b0);
    chk("e_perror_sticky", o_perror, 1);

    // Reset in the middle of tag1's data; late responses then miss.
    issue_cmd(64'h1F0, 18'h220, 9'h0AA);
    expect_req("f0", 2'd0, 64'h1F0, 12'h010);
    take_req();
    send_beats("f0", 1, 2'd0, -1);
    expect_req("f1", 2'd1, 64'h200, 12'h200);
    take_req();
    send_beats("f1", 10, 2'd1, -1);
    reset = 1'b0;
    check_all_zero("rst_mid");
    perr_exp = 1'b0;
    reset = 1'b1;
    tick();
    send_rsp("f_late1", 1'b0, UIDV, 2'd1, 1'b1);
    send_rsp("f_late0", 1'b0, UIDV, 2'd0, 1'b1);
    issue_cmd(64'h40, 18'h10, 9'h0CC);
    expect_req("g0", 2'd0, 64'h40, 12'h010);
    take_req();
    send_beats("g0", 1, 2'd0, -1);
    send_rsp("g_r0", 1'b0, UIDV, 2'd0, 1'b0);
    wait_done("g", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
